// File: rtl/button_debounce_pkg.sv
// Shared types and default timing constants for the push-button debouncer.
package button_debounce_pkg;

    typedef enum logic [1:0] {
        RELEASED   = 2'd0,
        PRESS_WAIT = 2'd1,
        PRESSED    = 2'd2,
        REL_WAIT   = 2'd3
    } deb_state_t;

    localparam int DEF_N      = 3;
    localparam int DEF_CDIV   = 3;
    localparam int DEF_STABLE = 2;
    localparam int DEF_HOLD   = 4;

endpackage

// File: rtl/button_debounce_bit.sv
// One debounce channel: stability FSM, hold timer and edge pulses for a synchronised input.
module debounce_bit
    import button_debounce_pkg::*;
#(
    parameter int STABLE = DEF_STABLE,
    parameter int HOLD   = DEF_HOLD
) (
    input  logic clk,
    input  logic n_rst,
    input  logic tick,
    input  logic act,
    output logic pressed,
    output logic press_p,
    output logic release_p,
    output logic hold_p
);

    localparam int CW = $clog2(STABLE + 1);
    localparam int HW = $clog2(HOLD + 1);
    localparam logic [CW-1:0] STABLE_M1 = CW'(STABLE - 1);
    localparam logic [HW-1:0] HOLD_C    = HW'(HOLD);
    localparam logic [HW-1:0] HOLD_M1   = HW'(HOLD - 1);

    deb_state_t    state;
    logic [CW-1:0] cnt;
    logic [HW-1:0] hcnt;
    logic          pressed_d;
    logic          hold_q;

    // State only moves on prescaler ticks; pulses are derived from the registered level.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= RELEASED;
            cnt       <= '0;
            hcnt      <= '0;
            pressed_d <= 1'b0;
            hold_q    <= 1'b0;
        end else begin
            pressed_d <= pressed;
            hold_q    <= 1'b0;
            if (tick) begin
                case (state)
                    RELEASED: begin
                        if (act) begin
                            if (STABLE <= 1) begin
                                state <= PRESSED;
                            end else begin
                                state <= PRESS_WAIT;
                                cnt   <= CW'(1);
                            end
                        end
                    end
                    PRESS_WAIT: begin
                        if (!act) begin
                            state <= RELEASED;
                            cnt   <= '0;
                        end else if (cnt == STABLE_M1) begin
                            state <= PRESSED;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    PRESSED: begin
                        if (!act) begin
                            if (STABLE <= 1) begin
                                state <= RELEASED;
                                hcnt  <= '0;
                            end else begin
                                state <= REL_WAIT;
                                cnt   <= CW'(1);
                            end
                        end else if (hcnt != HOLD_C) begin
                            hcnt <= hcnt + HW'(1);
                            if (hcnt == HOLD_M1) begin
                                hold_q <= 1'b1;
                            end
                        end
                    end
                    REL_WAIT: begin
                        if (act) begin
                            state <= PRESSED;
                            cnt   <= '0;
                        end else if (cnt == STABLE_M1) begin
                            state <= RELEASED;
                            cnt   <= '0;
                            hcnt  <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: begin
                        state <= RELEASED;
                        cnt   <= '0;
                        hcnt  <= '0;
                    end
                endcase
            end
        end
    end

    assign pressed   = (state == PRESSED) || (state == REL_WAIT);
    assign press_p   = pressed & ~pressed_d;
    assign release_p = ~pressed & pressed_d;
    assign hold_p    = hold_q;

endmodule

// File: rtl/button_debounce.sv
// Synchronises active-low button pins and debounces each one with a shared sample tick.
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int CDIV   = DEF_CDIV,
    parameter int STABLE = DEF_STABLE,
    parameter int HOLD   = DEF_HOLD
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic [N-1:0] btn,
    output logic [N-1:0] pressed,
    output logic [N-1:0] press_p,
    output logic [N-1:0] release_p,
    output logic [N-1:0] hold_p
);

    localparam int PW = $clog2(CDIV + 1);
    localparam logic [PW-1:0] CDIV_C = PW'(CDIV);

    logic [PW-1:0] presc;
    logic          tick;
    logic [N-1:0]  sync1;
    logic [N-1:0]  sync2;
    logic [N-1:0]  act;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            presc <= '0;
        end else if (presc == CDIV_C) begin
            presc <= PW'(1);
        end else begin
            presc <= presc + PW'(1);
        end
    end

    assign tick = (presc == CDIV_C);

    // Synchroniser resets to the released pin level so nothing looks pressed out of reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    assign act = ~sync2;

    for (genvar i = 0; i < N; i++) begin : g_chan
        debounce_bit #(
            .STABLE (STABLE),
            .HOLD   (HOLD)
        ) u_bit (
            .clk       (clk),
            .n_rst     (n_rst),
            .tick      (tick),
            .act       (act[i]),
            .pressed   (pressed[i]),
            .press_p   (press_p[i]),
            .release_p (release_p[i]),
            .hold_p    (hold_p[i])
        );
    end

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce: expected pulse events are queued when pins change.
module tb_button_debounce;

    localparam int N      = 3;
    localparam int CDIV   = 3;
    localparam int STABLE = 2;
    localparam int HOLD   = 4;

    localparam int EV_PRESS   = 0;
    localparam int EV_RELEASE = 1;
    localparam int EV_HOLD    = 2;

    logic         clk = 1'b0;
    logic         n_rst;
    logic [N-1:0] btn;
    logic [N-1:0] pressed;
    logic [N-1:0] press_p;
    logic [N-1:0] release_p;
    logic [N-1:0] hold_p;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int sb[$];
    int press_cyc[N];
    int hold_cyc[N];

    button_debounce #(
        .N      (N),
        .CDIV   (CDIV),
        .STABLE (STABLE),
        .HOLD   (HOLD)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .btn       (btn),
        .pressed   (pressed),
        .press_p   (press_p),
        .release_p (release_p),
        .hold_p    (hold_p)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] value);
        @(posedge clk);
        #2 btn = value;
    endtask

    task automatic pushEvent(input int kind, input int ch);
        sb.push_back(kind * 4 + ch);
    endtask

    task automatic waitDrain(input string tag, input int max_cycles);
        int n = 0;
        while (sb.size() != 0 && n < max_cycles) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput(tag, sb.size(), 0);
        if (sb.size() != 0) sb.delete();
    endtask

    task automatic checkLevel(input string tag, input logic [N-1:0] exp, input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            checkOutput(tag, pressed, exp);
        end
    endtask

    // Every pulse seen must match the oldest queued event; stray pulses are reported.
    always @(negedge clk) begin
        if (n_rst === 1'b1) begin
            for (int ch = 0; ch < N; ch++) begin
                for (int kind = 0; kind < 3; kind++) begin
                    logic hit;
                    hit = (kind == EV_PRESS)   ? press_p[ch] :
                          (kind == EV_RELEASE) ? release_p[ch] : hold_p[ch];
                    if (hit) begin
                        if (kind == EV_PRESS) press_cyc[ch] <= cyc;
                        if (kind == EV_HOLD)  hold_cyc[ch]  <= cyc;
                        if (sb.size() == 0) checkOutput("unexpected_event", kind * 4 + ch, 32'hff);
                        else                checkOutput("event", kind * 4 + ch, sb.pop_front());
                    end
                end
            end
            if ((press_p | release_p | hold_p) != '0)
                checkOutput("press_release_excl", press_p & release_p, 0);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: observed running expected finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        n_rst = 1'b0;
        btn   = 3'b000;
        repeat (3) @(negedge clk);
        checkOutput("rst_pressed", pressed, 0);
        checkOutput("rst_press_p", press_p, 0);
        checkOutput("rst_release_p", release_p, 0);
        checkOutput("rst_hold_p", hold_p, 0);
        checkOutput("rst_prescaler", dut.presc, 0);

        btn = 3'b111;
        @(negedge clk);
        #2 n_rst = 1'b1;
        checkLevel("idle_level", 3'b000, 10);

        pushEvent(EV_PRESS, 0);
        applyStimulus(3'b110);
        waitDrain("press0", 15);
        checkOutput("press0_level", pressed, 3'b001);
        pushEvent(EV_HOLD, 0);
        checkLevel("press0_steady", 3'b001, 10);
        waitDrain("hold0", 20);

        applyStimulus(3'b100);
        @(posedge clk);
        applyStimulus(3'b110);
        checkLevel("glitch1_level", 3'b001, 12);

        pushEvent(EV_PRESS, 2);
        pushEvent(EV_HOLD, 2);
        applyStimulus(3'b010);
        waitDrain("press2_hold2", 40);
        checkOutput("hold2_delay", hold_cyc[2] - press_cyc[2], HOLD * CDIV);
        checkLevel("hold2_no_repeat", 3'b101, 15);
        pushEvent(EV_RELEASE, 2);
        applyStimulus(3'b110);
        waitDrain("release2", 15);
        checkOutput("release2_level", pressed, 3'b001);

        applyStimulus(3'b111);
        @(posedge clk);
        @(posedge clk);
        applyStimulus(3'b110);
        checkLevel("bounce0_level", 3'b001, 12);

        pushEvent(EV_RELEASE, 0);
        applyStimulus(3'b111);
        waitDrain("release0", 15);
        checkOutput("release0_level", pressed, 3'b000);

        pushEvent(EV_PRESS, 0);
        applyStimulus(3'b110);
        waitDrain("press0_again", 15);
        @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        checkOutput("midrst_pressed", pressed, 0);
        checkOutput("midrst_release_p", release_p, 0);
        checkOutput("midrst_press_p", press_p, 0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("midrst_no_release", release_p, 0);
        end
        #2 n_rst = 1'b1;
        pushEvent(EV_PRESS, 0);
        pushEvent(EV_HOLD, 0);
        waitDrain("repress0", 40);

        pushEvent(EV_RELEASE, 0);
        applyStimulus(3'b111);
        waitDrain("final_release", 15);
        checkLevel("final_idle", 3'b000, 5);
        checkOutput("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
